// File: rtl/fa_ha_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fa_ha_pkg
// Brief    : Shared constants for the fa_ha ripple-carry full adder.
// Revision : 1.0 - initial release
// ============================================================================
package fa_ha_pkg;

  // Default operand width: the single-bit full-adder leaf.
  localparam int DEFAULT_WIDTH = 1;

endpackage : fa_ha_pkg
`default_nettype wire

// File: rtl/fa_ha_half_adder.sv
`default_nettype none
// ============================================================================
// Module   : fa_ha_half_adder
// Brief    : Single-bit half adder; two of these form one full-adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module fa_ha_half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);

  // Sum is the XOR and carry is the AND of the two inputs.
  assign s  = x ^ y;
  assign co = x & y;

endmodule : fa_ha_half_adder
`default_nettype wire

// File: rtl/fa_ha.sv
`default_nettype none
// ============================================================================
// Module   : fa_ha
// Brief    : WIDTH-bit ripple-carry adder built from half-adder pairs, with an
//            optional single-cycle output register stage.
// Revision : 1.0 - initial release
// ============================================================================
module fa_ha
  import fa_ha_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic [WIDTH-1:0] S,
  output logic             CA
);

  // Carry chain: carry[0] is the carry-in, carry[WIDTH] the carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = C;

  // One full-adder cell per bit: HA1 on the operands, HA2 adds the carry.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic p;
    logic g1;
    logic g2;

    fa_ha_half_adder u_ha1 (
      .x  (A[i]),
      .y  (B[i]),
      .s  (p),
      .co (g1)
    );

    fa_ha_half_adder u_ha2 (
      .x  (p),
      .y  (carry[i]),
      .s  (sum[i]),
      .co (g2)
    );

    // At most one of g1/g2 can be set, so OR merges them into the carry.
    assign carry[i+1] = g1 | g2;
  end : g_cell

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] s_q;
    logic             ca_q;

    // Capture the adder result every edge; reset wins over capture.
    always_ff @(posedge clk) begin
      if (rst) begin
        s_q  <= '0;
        ca_q <= 1'b0;
      end else begin
        s_q  <= sum;
        ca_q <= carry[WIDTH];
      end
    end

    assign S  = s_q;
    assign CA = ca_q;
  end : g_reg
  else begin : g_comb
    // Clock and reset have no role in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign S  = sum;
    assign CA = carry[WIDTH];
  end : g_comb

endmodule : fa_ha
`default_nettype wire

// File: tb/tb_fa_ha.sv
`default_nettype none
// ============================================================================
// Module   : tb_fa_ha
// Brief    : Directed self-checking bench for fa_ha (registered 1- and 4-bit
//            builds plus the combinational 1-bit build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fa_ha;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // WIDTH=1 registered instance
  logic [0:0] a1 = '0, b1 = '0, s1;
  logic       c1 = 1'b0, ca1;
  // WIDTH=4 registered instance
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       c4 = 1'b0, ca4;
  // WIDTH=1 combinational instance
  logic [0:0] ac = '0, bc = '0, sc;
  logic       cc = 1'b0, cac;

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-written truth table, index = {A,B,C}, value = {S,CA}.
  logic [1:0] truth [8] = '{2'b00, 2'b10, 2'b10, 2'b01,
                            2'b10, 2'b01, 2'b01, 2'b11};

  always #5 clk = ~clk;

  fa_ha #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .C(c1), .S(s1), .CA(ca1)
  );

  fa_ha #(.WIDTH(4), .REG_OUT(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .C(c4), .S(s4), .CA(ca4)
  );

  fa_ha #(.WIDTH(1), .REG_OUT(1'b0)) u_dutc (
    .clk(clk), .rst(rst), .A(ac), .B(bc), .C(cc), .S(sc), .CA(cac)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two edges.
    rst = 1'b1;
    tick();
    tick();
    check("rst1_s1", {31'd0, s1}, 32'd0);
    check("rst1_ca1", {31'd0, ca1}, 32'd0);
    check("rst1_s4", {28'd0, s4}, 32'd0);
    check("rst1_ca4", {31'd0, ca4}, 32'd0);

    // Full truth table sweep with one-cycle latency.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a1, b1, c1} = v;
      tick();
      check($sformatf("tt%0d_s", i), {31'd0, s1}, {31'd0, truth[i][1]});
      check($sformatf("tt%0d_ca", i), {31'd0, ca1}, {31'd0, truth[i][0]});
    end

    // Reset has priority over capture.
    {a1, b1, c1} = 3'b111;
    rst = 1'b1;
    tick();
    check("rprio_s", {31'd0, s1}, 32'd0);
    check("rprio_ca", {31'd0, ca1}, 32'd0);
    rst = 1'b0;
    tick();
    check("rrel_s", {31'd0, s1}, 32'd1);
    check("rrel_ca", {31'd0, ca1}, 32'd1);

    // Mid-stream reset discards the in-flight 110 result.
    {a1, b1, c1} = 3'b101;
    tick();
    check("mid101_s", {31'd0, s1}, 32'd0);
    check("mid101_ca", {31'd0, ca1}, 32'd1);
    {a1, b1, c1} = 3'b110;
    rst = 1'b1;
    tick();
    check("mid110_s", {31'd0, s1}, 32'd0);
    check("mid110_ca", {31'd0, ca1}, 32'd0);
    rst = 1'b0;

    // 4-bit carry ripple and no-carry cases.
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    tick();
    check("w4_rip_s", {28'd0, s4}, 32'h0);
    check("w4_rip_ca", {31'd0, ca4}, 32'd1);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    tick();
    check("w4_max_s", {28'd0, s4}, 32'hF);
    check("w4_max_ca", {31'd0, ca4}, 32'd1);
    a4 = 4'h5; b4 = 4'hA; c4 = 1'b0;
    tick();
    check("w4_5a_s", {28'd0, s4}, 32'hF);
    check("w4_5a_ca", {31'd0, ca4}, 32'd0);
    a4 = 4'h3; b4 = 4'h4; c4 = 1'b1;
    tick();
    check("w4_34_s", {28'd0, s4}, 32'h8);
    check("w4_34_ca", {31'd0, ca4}, 32'd0);
    a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
    tick();
    check("w4_zero_s", {28'd0, s4}, 32'h0);
    check("w4_zero_ca", {31'd0, ca4}, 32'd0);
    a4 = 4'h9; b4 = 4'h7; c4 = 1'b0;
    tick();
    check("w4_97_s", {28'd0, s4}, 32'h0);
    check("w4_97_ca", {31'd0, ca4}, 32'd1);

    // Combinational build: rst held high, checks straddle clock edges.
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {ac, bc, cc} = v;
      if (i % 2 == 1) @(posedge clk);
      #1;
      check($sformatf("comb%0d_s", i), {31'd0, sc}, {31'd0, truth[i][1]});
      check($sformatf("comb%0d_ca", i), {31'd0, cac}, {31'd0, truth[i][0]});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_fa_ha
`default_nettype wire
